// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART RX state type and constants; UART_RX_PARITY_EN adds the PARITY state
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
  localparam int SEL_BIT              = 7;     // received bit that picks latch A (0) or B (1)

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART deserializer (sync, FSM, bit timer, shift reg); UART_RX_PARITY_EN adds even parity
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       good_stb,
  output logic       ferr_stb
`ifdef UART_RX_PARITY_EN
  ,
  output logic       perr_stb
`endif
);

  localparam int            TW      = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_s;
  logic [1:0]    sync_age;
  logic          armed;
  rx_state_t     state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shreg, shreg_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_d;
`endif

  assign rx_byte = shreg;

  // Synchronize rx; start detection is armed only once a real high level has
  // propagated after reset, so a reset that lands mid-frame cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      sync_age <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      sync_age <= {sync_age[0], 1'b1};
      armed    <= armed | (sync_age[1] & rx_s);
    end
  end

  // FSM state, bit timer, bit counter and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_d;
`endif
    end
  end

  // Next-state logic; the timer is cleared at every sample point so it never wraps mid-bit
  always_comb begin
    state_d   = state;
    timer_d   = timer + TW'(1);
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    good_stb  = 1'b0;
    ferr_stb  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad;
    perr_stb  = 1'b0;
`endif
    case (state)
      IDLE: begin
        timer_d = '0;
        if (!rx_s && armed) state_d = START;
      end
      START: begin
        if (timer == HALF_M1) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == FULL_M1) begin
          timer_d   = '0;
          shreg_d   = {rx_s, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_d = PARITY;
`else
          if (bit_cnt == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer == FULL_M1) begin
          timer_d   = '0;
          par_bad_d = rx_s ^ (^shreg);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (timer == FULL_M1) begin
          timer_d = '0;
          if (rx_s) begin
            state_d  = IDLE;
`ifdef UART_RX_PARITY_EN
            good_stb = !par_bad;
            perr_stb = par_bad;
`else
            good_stb = 1'b1;
`endif
          end else begin
            state_d  = RECOVER;
            ferr_stb = 1'b1;
          end
        end
      end
      RECOVER: begin
        timer_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_rx_latch.sv
// rtl/uart_rx_latch.sv - UART byte receiver steering the low nibble into latch A or B; UART_RX_PARITY_EN adds par_err
module uart_rx_latch
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] q_a,
  output logic [3:0] q_b,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       par_err
`endif
);

  logic [7:0] rx_byte;
  logic       good_stb, ferr_stb;
`ifdef UART_RX_PARITY_EN
  logic       perr_stb;
`endif

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .good_stb (good_stb),
    .ferr_stb (ferr_stb)
`ifdef UART_RX_PARITY_EN
    ,
    .perr_stb (perr_stb)
`endif
  );

  // Register the status pulses and, on a good byte only, the data and the selected latch
  always_ff @(posedge clk) begin
    if (reset) begin
      q_a       <= '0;
      q_b       <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      rx_valid  <= good_stb;
      frame_err <= ferr_stb;
`ifdef UART_RX_PARITY_EN
      par_err   <= perr_stb;
`endif
      if (good_stb) begin
        rx_data <= rx_byte;
        if (rx_byte[SEL_BIT]) q_b <= rx_byte[3:0];
        else                  q_a <= rx_byte[3:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_latch.sv
// tb/tb_uart_rx_latch.sv - self-checking bench for uart_rx_latch; covers UART_RX_PARITY_EN when defined
module tb_uart_rx_latch;

  localparam int CPB     = 16;
  localparam int EV_GOOD = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] q_a, q_b;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
  logic       par_flip = 1'b0;
`endif

  uart_rx_latch #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .q_a       (q_a),
    .q_b       (q_b),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulse_cnt = 0;
  int         exp_kind[$];
  logic [7:0] exp_byte[$];
  logic [3:0] m_qa = 4'h0, m_qb = 4'h0;
  logic [7:0] m_data = 8'h00;
  logic       stop_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A DUT pulse must match the oldest outstanding frame outcome and arrive during its stop bit
  task automatic observe(input int kind);
    logic [7:0] b;
    pulse_cnt++;
    check("pulse_expected", (exp_kind.size() != 0 && stop_phase) ? 32'd1 : 32'd0, 32'd1);
    if (exp_kind.size() != 0) begin
      b = exp_byte[0];
      check("pulse_kind", 32'(kind), 32'(exp_kind[0]));
      if (kind == EV_GOOD) begin
        m_data = b;
        if (b[7]) m_qb = b[3:0];
        else      m_qa = b[3:0];
      end
      void'(exp_kind.pop_front());
      void'(exp_byte.pop_front());
    end
  endtask

  // Per-cycle compare against the model, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (reset) begin
      m_qa = 4'h0;
      m_qb = 4'h0;
      m_data = 8'h00;
      exp_kind.delete();
      exp_byte.delete();
      check("reset_pulses", {30'd0, rx_valid, frame_err}, 32'd0);
    end else begin
      check("pulse_overlap", {31'd0, rx_valid & frame_err}, 32'd0);
      if (rx_valid)  observe(EV_GOOD);
      if (frame_err) observe(EV_FERR);
`ifdef UART_RX_PARITY_EN
      check("par_overlap", {31'd0, par_err & (rx_valid | frame_err)}, 32'd0);
      if (par_err)   observe(EV_PERR);
`endif
    end
    check("q_a", {28'd0, q_a}, {28'd0, m_qa});
    check("q_b", {28'd0, q_b}, {28'd0, m_qb});
    check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int stop_low);
    stop_phase = 1'b0;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ par_flip, CPB);
`endif
    stop_phase = 1'b1;
    if (stop_low > 0) drive(1'b0, stop_low);
    drive(1'b1, CPB);
  endtask

  task automatic frame(input logic [7:0] b, input int stop_low, input int gap);
    int kind;
    kind = (stop_low > 0) ? EV_FERR : EV_GOOD;
`ifdef UART_RX_PARITY_EN
    if (stop_low == 0 && par_flip) kind = EV_PERR;
`endif
    exp_kind.push_back(kind);
    exp_byte.push_back(b);
    send_bits(b, stop_low);
    drive(1'b1, gap);
    check("frame_outcome_seen", 32'(exp_kind.size()), 32'd0);
  endtask

  task automatic glitch(input int len);
    stop_phase = 1'b0;
    drive(1'b0, len);
    drive(1'b1, 2 * CPB);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int r;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_q_a", {28'd0, q_a}, 32'h0);
    check("rst_q_b", {28'd0, q_b}, 32'h0);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    drive(1'b1, 8);

    p0 = pulse_cnt;
    frame(8'h05, 0, 4);
    check("t05_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("t05_rx_data", {24'd0, rx_data}, 32'h05);
    check("t05_q_a", {28'd0, q_a}, 32'h5);
    check("t05_q_b", {28'd0, q_b}, 32'h0);

    p0 = pulse_cnt;
    frame(8'h8C, 0, 4);
    check("t8c_q_b", {28'd0, q_b}, 32'hC);
    frame(8'h03, 0, 4);
    check("t03_q_a", {28'd0, q_a}, 32'h3);
    check("t03_q_b", {28'd0, q_b}, 32'hC);
    check("t8c03_pulses", 32'(pulse_cnt - p0), 32'd2);

    p0 = pulse_cnt;
    glitch(4);
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("glitch_q_a", {28'd0, q_a}, 32'h3);
    check("glitch_q_b", {28'd0, q_b}, 32'hC);
    check("glitch_rx_data", {24'd0, rx_data}, 32'h03);

    p0 = pulse_cnt;
    frame(8'h8F, 20, 4);
    check("badstop_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("badstop_q_b", {28'd0, q_b}, 32'hC);
    frame(8'h81, 0, 4);
    check("t81_q_b", {28'd0, q_b}, 32'h1);

    p0 = pulse_cnt;
    stop_phase = 1'b0;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(r_bit(8'h8A, i), CPB);
    drive(1'b0, 5);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midrst_q_a", {28'd0, q_a}, 32'h0);
    check("midrst_q_b", {28'd0, q_b}, 32'h0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    drive(1'b0, CPB - 8);
    for (int i = 5; i < 8; i++) drive(r_bit(8'h8A, i), CPB);
    drive(1'b1, 2 * CPB);
    check("midrst_pulses", 32'(pulse_cnt - p0), 32'd0);
    frame(8'h02, 0, 4);
    check("t02_q_a", {28'd0, q_a}, 32'h2);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    frame(8'h07, 0, 4);
    check("perr_q_a", {28'd0, q_a}, 32'h2);
    par_flip = 1'b0;
    frame(8'h07, 0, 4);
    check("pok_q_a", {28'd0, q_a}, 32'h7);
`endif

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 4) == 0);
`endif
      if (r < 70)      frame(8'($urandom_range(0, 255)), 0, int'($urandom_range(2, 20)));
      else if (r < 85) frame(8'($urandom_range(0, 255)), int'($urandom_range(14, 30)), int'($urandom_range(2, 20)));
      else begin
        p0 = pulse_cnt;
        glitch(int'($urandom_range(1, 5)));
        check("rnd_glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic r_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
